wishbone_bridge_1ton: RTL and testbench
=======================================

// Module: wishbone_bridge_1toN
// PURPOSE
//   Registered WISHBONE classic-cycle bridge from one master to N_SLAVES slaves.
//   - Decodes the address against per-slave BASE/MASK windows.
//   - Adds byte selects (SEL) and an error response (ERR).
//   - Bus watchdog converts hung or unmapped accesses into ERR.
//   - Sits between the MMIO master and the peripheral cores.
// PARAMETERS
//   ADDR_WIDTH     32                     address width
//   DATA_WIDTH     32                     data width; multiple of 8
//   N_SLAVES       4                      slave count, 1..16
//   SLV_BASE       {N_SLAVES{32'h0}}      packed array, base address per slave
//   SLV_MASK       {N_SLAVES{32'hF000_0000}}  packed array, compare mask per slave
//   TIMEOUT_CYCLES 255                    max slave-wait cycles before ERR, >=1
// PORTS
//   CLK       in   1                 clock, rising edge
//   RST_N     in   1                 async assert, active-low reset
//   M_ADDR    in   ADDR_WIDTH        master address
//   M_DAT_I   in   DATA_WIDTH        master write data
//   M_SEL     in   DATA_WIDTH/8      byte selects
//   M_CYC     in   1                 master cycle
//   M_STB     in   1                 master strobe
//   M_WE      in   1                 write enable
//   M_DAT_O   out  DATA_WIDTH        read data to master
//   M_ACK     out  1                 normal termination
//   M_ERR     out  1                 error termination (unmapped or timeout)
//   S_ADDR    out  ADDR_WIDTH        shared slave address (registered)
//   S_DAT_I   out  DATA_WIDTH        shared slave write data (registered)
//   S_SEL     out  DATA_WIDTH/8      shared byte selects (registered)
//   S_WE      out  1                 shared write enable (registered)
//   S_CYC     out  N_SLAVES          per-slave cycle, one-hot or zero
//   S_STB     out  N_SLAVES          per-slave strobe, one-hot or zero
//   S_DAT_O   in   N_SLAVES*DATA_WIDTH  slave read data, slave i at [i*DW +: DW]
//   S_ACK     in   N_SLAVES          slave acks
// BEHAVIOUR
//   Reset values (all outputs, RST_N low): M_ACK=0, M_ERR=0, M_DAT_O=0,
//     S_CYC=0, S_STB=0, S_ADDR/S_DAT_I/S_SEL/S_WE=0, FSM=IDLE, watchdog=0.
//   Decode: slave i hits when (M_ADDR & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]).
//     Multiple hits resolve to the lowest index. No hit means unmapped.
//   FSM: IDLE, WAIT, RESP, ERR.
//   - IDLE: on M_CYC&M_STB, register ADDR/DAT/SEL/WE and latch the slave index.
//     - Hit: go to WAIT; S_CYC[i]=S_STB[i]=1 from the next cycle.
//     - Unmapped: go to ERR.
//   - WAIT: watchdog increments each cycle.
//     - S_ACK[i]: capture S_DAT_O slice into M_DAT_O (reads only; writes leave
//       M_DAT_O unchanged), drop S_CYC/S_STB, go to RESP.
//     - Watchdog==TIMEOUT_CYCLES with no ACK: drop S_CYC/S_STB, go to ERR.
//     - S_ACK and timeout in the same cycle: ACK wins.
//     - S_ACK from a non-selected slave is ignored.
//   - RESP: M_ACK=1 for exactly one cycle, then IDLE.
//   - ERR: M_ERR=1 for exactly one cycle, M_DAT_O unchanged, then IDLE.
//   Latency, mapped access: M_ACK 2 cycles after the slave ACK edge; a
//     zero-wait slave gives M_ACK on the 3rd edge after the request.
//   Latency, unmapped access: M_ERR on the 2nd edge after the request.
//   Abort: M_CYC low in WAIT drops S_CYC/S_STB next edge, returns to IDLE,
//     no ACK/ERR. A late slave ACK is then ignored.
//   M_ACK and M_ERR are never high together. No pipelining: one outstanding access.
//   Request present during RESP/ERR is not sampled; it is accepted from IDLE.
//   Watchdog is clog2(TIMEOUT_CYCLES+1) bits, cleared on entering WAIT, never wraps.
//   RST_N asserted mid-transfer: all outputs clear immediately (async).
// STRUCTURE
//   wishbone_pkg: state enum wb_state_e {IDLE,WAIT,RESP,ERR}; function
//     sel_width(DW)=DW/8.
//   Sub-module wb_addr_decoder (combinational): M_ADDR -> hit flag + slave index.
//   FSM, watchdog and data registers live in this module.
// TESTING
//   1 Read slave 2 (base 0x2000_0000), slave ACKs 1 cycle after S_STB, data
//     0xDEAD_BEEF -> M_DAT_O=0xDEAD_BEEF, M_ACK one-cycle pulse, S_CYC=4'b0100
//     while waiting.
//   2 Write 0x1234_5678, SEL=4'b0011 to slave 0 -> S_DAT_I/S_SEL match,
//     S_WE=1, M_ACK once, M_DAT_O unchanged.
//   3 Access 0xF000_0000 (unmapped) -> M_ERR on the 2nd edge, S_CYC stays 0.
//   4 TIMEOUT_CYCLES=8, slave never ACKs -> S_STB drops and M_ERR pulses after
//     8 WAIT cycles; next access completes normally.
//   5 Master drops M_CYC in WAIT, slave ACKs one cycle later -> no M_ACK/M_ERR,
//     FSM back in IDLE.
//   6 RST_N low during WAIT -> S_CYC/S_STB/M_ACK=0 immediately; after release,
//     a read returns correct data.

Source files
------------

// File: rtl/wishbone_bridge_1ton_pkg.sv
// Shared types and helpers for the 1-to-N WISHBONE bridge.
//   wb_state_e : bridge FSM state encoding
//   sel_width  : byte-select width for a given data width
//   idx_width  : width of a slave index (at least 1 bit)
package wishbone_bridge_1ton_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StErr
  } wb_state_e;

  function automatic int unsigned sel_width(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wishbone_bridge_1ton_addr_decoder.sv
// Combinational address decoder for the 1-to-N WISHBONE bridge.
// Slave i hits when (addr & MASK[i]) == (BASE[i] & MASK[i]); the lowest
// hitting index wins.
// Ports:
//   i_addr : master address
//   o_hit  : at least one slave window matches
//   o_idx  : index of the lowest matching slave (0 when no hit)
module wishbone_bridge_1ton_addr_decoder
  import wishbone_bridge_1ton_pkg::*;
#(
  parameter int unsigned                     ADDR_WIDTH = 32,
  parameter int unsigned                     N_SLAVES   = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLV_BASE   = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLV_MASK   = '0
) (
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  output logic                             o_hit,
  output logic [idx_width(N_SLAVES)-1:0]   o_idx
);

  localparam int unsigned IDX_W = idx_width(N_SLAVES);

  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_mask;

  // Scan from the highest index down so the lowest hitting index is the
  // last assignment and therefore wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_base = '0;
    w_mask = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      w_base = SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_mask = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((i_addr & w_mask) == (w_base & w_mask)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wishbone_bridge_1ton.sv
// Registered WISHBONE classic-cycle bridge, one master to N_SLAVES slaves.
// One access is outstanding at a time. Unmapped addresses and slaves that do
// not acknowledge within TIMEOUT_CYCLES wait cycles terminate with M_ERR.
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_m_*                    : master request (addr, write data, sel, cyc, stb, we)
//   o_m_dat, o_m_ack, o_m_err: master response (registered)
//   o_s_addr/dat/sel/we      : shared slave request fields (registered)
//   o_s_cyc, o_s_stb         : per-slave one-hot cycle/strobe (registered)
//   i_s_dat, i_s_ack         : slave read data (slave i at [i*DW +: DW]) and acks
module wishbone_bridge_1ton
  import wishbone_bridge_1ton_pkg::*;
#(
  parameter int unsigned                     ADDR_WIDTH     = 32,
  parameter int unsigned                     DATA_WIDTH     = 32,
  parameter int unsigned                     N_SLAVES       = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLV_BASE       = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0]  SLV_MASK       = {N_SLAVES{32'hF000_0000}},
  parameter int unsigned                     TIMEOUT_CYCLES = 255
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  // master side
  input  logic [ADDR_WIDTH-1:0]             i_m_addr,
  input  logic [DATA_WIDTH-1:0]             i_m_dat,
  input  logic [sel_width(DATA_WIDTH)-1:0]  i_m_sel,
  input  logic                              i_m_cyc,
  input  logic                              i_m_stb,
  input  logic                              i_m_we,
  output logic [DATA_WIDTH-1:0]             o_m_dat,
  output logic                              o_m_ack,
  output logic                              o_m_err,
  // slave side
  output logic [ADDR_WIDTH-1:0]             o_s_addr,
  output logic [DATA_WIDTH-1:0]             o_s_dat,
  output logic [sel_width(DATA_WIDTH)-1:0]  o_s_sel,
  output logic                              o_s_we,
  output logic [N_SLAVES-1:0]               o_s_cyc,
  output logic [N_SLAVES-1:0]               o_s_stb,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]    i_s_dat,
  input  logic [N_SLAVES-1:0]               i_s_ack
);

  localparam int unsigned SW    = sel_width(DATA_WIDTH);
  localparam int unsigned IW    = idx_width(N_SLAVES);
  localparam int unsigned WDW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] TO_VAL = WDW'(TIMEOUT_CYCLES);

  wb_state_e r_state;
  wb_state_e w_state_d;

  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_dat;
  logic [SW-1:0]         r_s_sel;
  logic                  r_s_we;
  logic [N_SLAVES-1:0]   r_s_cyc;
  logic [IW-1:0]         r_idx;
  logic [WDW-1:0]        r_wd;
  logic [DATA_WIDTH-1:0] r_m_dat;
  logic                  r_m_ack;
  logic                  r_m_err;

  logic                  w_hit;
  logic [IW-1:0]         w_idx;
  logic [N_SLAVES-1:0]   w_onehot;
  logic                  w_sel_ack;
  logic [DATA_WIDTH-1:0] w_sel_dat;
  logic [WDW-1:0]        w_wd_plus;

  logic w_accept;
  logic w_capture;
  logic w_drop;
  logic w_wd_inc;
  logic w_ack_set;
  logic w_err_set;

  wishbone_bridge_1ton_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SLAVES   (N_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decoder (
    .i_addr (i_m_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_onehot  = N_SLAVES'(1) << w_idx;
  assign w_sel_ack = i_s_ack[r_idx];
  assign w_sel_dat = i_s_dat[r_idx*DATA_WIDTH +: DATA_WIDTH];
  // Counts the current wait cycle; reaching TO_VAL means the budget is used up.
  assign w_wd_plus = r_wd + WDW'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_drop    = 1'b0;
    w_wd_inc  = 1'b0;
    w_ack_set = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        // While the termination pulse is visible the master is still holding
        // the request it just completed; do not take it a second time.
        if (i_m_cyc && i_m_stb && !r_m_ack && !r_m_err) begin
          w_accept  = 1'b1;
          w_state_d = w_hit ? StWait : StErr;
        end
      end
      StWait: begin
        if (!i_m_cyc) begin
          w_drop    = 1'b1;
          w_state_d = StIdle;
        end else if (w_sel_ack) begin
          // Ack has priority over a simultaneous watchdog expiry.
          w_drop    = 1'b1;
          w_capture = 1'b1;
          w_state_d = StResp;
        end else if (w_wd_plus == TO_VAL) begin
          w_drop    = 1'b1;
          w_state_d = StErr;
        end else begin
          w_wd_inc  = 1'b1;
        end
      end
      StResp: begin
        w_ack_set = 1'b1;
        w_state_d = StIdle;
      end
      StErr: begin
        w_err_set = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Request/response registers and watchdog
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_addr <= '0;
      r_s_dat  <= '0;
      r_s_sel  <= '0;
      r_s_we   <= 1'b0;
      r_s_cyc  <= '0;
      r_idx    <= '0;
      r_wd     <= '0;
      r_m_dat  <= '0;
      r_m_ack  <= 1'b0;
      r_m_err  <= 1'b0;
    end else begin
      r_m_ack <= w_ack_set;
      r_m_err <= w_err_set;
      if (w_accept) begin
        r_s_addr <= i_m_addr;
        r_s_dat  <= i_m_dat;
        r_s_sel  <= i_m_sel;
        r_s_we   <= i_m_we;
        r_idx    <= w_idx;
        r_wd     <= '0;
        r_s_cyc  <= w_hit ? w_onehot : '0;
      end
      if (w_drop) begin
        r_s_cyc <= '0;
      end
      if (w_wd_inc) begin
        r_wd <= w_wd_plus;
      end
      if (w_capture && !r_s_we) begin
        r_m_dat <= w_sel_dat;
      end
    end
  end

  assign o_s_addr = r_s_addr;
  assign o_s_dat  = r_s_dat;
  assign o_s_sel  = r_s_sel;
  assign o_s_we   = r_s_we;
  // CYC and STB are identical: there is never more than one strobe per cycle.
  assign o_s_cyc  = r_s_cyc;
  assign o_s_stb  = r_s_cyc;
  assign o_m_dat  = r_m_dat;
  assign o_m_ack  = r_m_ack;
  assign o_m_err  = r_m_err;

endmodule

// File: tb/tb_wishbone_bridge_1ton.sv
// Self-checking bench for wishbone_bridge_1ton: 4 slaves at 0x0/1/2/3000_0000
// (top-nibble windows), TIMEOUT_CYCLES = 8. Slaves are modelled by a responder
// that acks a programmable number of cycles after its strobe rises.
module tb_wishbone_bridge_1ton;

  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;

  logic         clk;
  logic         rst_n;
  logic [31:0]  m_addr;
  logic [31:0]  m_dat_w;
  logic [3:0]   m_sel;
  logic         m_cyc;
  logic         m_stb;
  logic         m_we;
  logic [31:0]  m_dat_r;
  logic         m_ack;
  logic         m_err;
  logic [31:0]  s_addr;
  logic [31:0]  s_dat_w;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [3:0]   s_cyc;
  logic [3:0]   s_stb;
  logic [127:0] s_dat_r;
  logic [3:0]   s_ack;

  // slave model state
  logic [31:0]  rd_data [4];
  int           lat [4];
  int           wcnt [4];
  logic [3:0]   resp_ack;
  logic [3:0]   force_ack;
  int           n_acks;
  logic [31:0]  cap_addr;
  logic [31:0]  cap_dat;
  logic [3:0]   cap_sel;
  logic         cap_we;

  int           n_tests;
  int           n_fail;
  logic [31:0]  exp_mdat;   // what M_DAT_O should hold (last successful read)

  assign s_dat_r = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
  assign s_ack   = resp_ack | force_ack;

  wishbone_bridge_1ton #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .N_SLAVES       (4),
    .SLV_BASE       ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK       ({4{32'hF000_0000}}),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_m_addr (m_addr),
    .i_m_dat  (m_dat_w),
    .i_m_sel  (m_sel),
    .i_m_cyc  (m_cyc),
    .i_m_stb  (m_stb),
    .i_m_we   (m_we),
    .o_m_dat  (m_dat_r),
    .o_m_ack  (m_ack),
    .o_m_err  (m_err),
    .o_s_addr (s_addr),
    .o_s_dat  (s_dat_w),
    .o_s_sel  (s_sel),
    .o_s_we   (s_we),
    .o_s_cyc  (s_cyc),
    .o_s_stb  (s_stb),
    .i_s_dat  (s_dat_r),
    .i_s_ack  (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave responder: ack lat[i] cycles after strobe rises, recording the
  // request fields seen at the ack.
  initial begin
    resp_ack = '0;
    n_acks   = 0;
    cap_addr = '0;
    cap_dat  = '0;
    cap_sel  = '0;
    cap_we   = 1'b0;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (s_stb[i]) begin
          resp_ack[i] = (wcnt[i] == lat[i]);
          if (resp_ack[i]) begin
            n_acks++;
            cap_addr = s_addr;
            cap_dat  = s_dat_w;
            cap_sel  = s_sel;
            cap_we   = s_we;
          end
          wcnt[i]++;
        end else begin
          resp_ack[i] = 1'b0;
          wcnt[i]     = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: slave number is the top address nibble when 0..3.
  function automatic int ref_slave(input logic [31:0] a);
    int nib;
    nib = int'(a >> 28);
    return (nib < 4) ? nib : -1;
  endfunction

  // Drive one access (caller is just after an edge); return what happened.
  task automatic do_access(input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           output int edges, output logic got_ack,
                           output logic got_err, output logic [31:0] rdat,
                           output logic cyc_bad, output int stb_cycles);
    int         slv;
    logic [3:0] oh;
    slv        = ref_slave(addr);
    oh         = (slv >= 0) ? (4'b0001 << slv) : 4'b0000;
    m_addr     = addr;
    m_we       = we;
    m_dat_w    = wdata;
    m_sel      = sel;
    m_cyc      = 1'b1;
    m_stb      = 1'b1;
    edges      = 0;
    got_ack    = 1'b0;
    got_err    = 1'b0;
    rdat       = '0;
    cyc_bad    = 1'b0;
    stb_cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (s_cyc != 4'b0000 && s_cyc != oh) cyc_bad = 1'b1;
      if (s_stb != s_cyc) cyc_bad = 1'b1;
      if (s_stb != 4'b0000) stb_cycles++;
      if (m_ack || m_err) begin
        got_ack = m_ack;
        got_err = m_err;
        rdat    = m_dat_r;
        edges   = n;
        break;
      end
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    m_addr  = '0;
    m_dat_w = '0;
    m_sel   = '0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    force_ack = '0;
    for (int i = 0; i < 4; i++) begin
      lat[i]     = 0;
      rd_data[i] = '0;
    end
    exp_mdat = '0;
    #23;
    n_tests++;
    if ({m_ack, m_err, m_dat_r} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_master: got ack=%b err=%b dat=%h, need 0 0 0", m_ack, m_err, m_dat_r);
    end
    n_tests++;
    if ({s_cyc, s_stb, s_addr, s_dat_w, s_sel, s_we} !== 77'h0) begin
      n_fail++;
      $display("FAIL reset_slave: got cyc=%b stb=%b addr=%h dat=%h sel=%b we=%b, need all 0",
               s_cyc, s_stb, s_addr, s_dat_w, s_sel, s_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Slave 2 read, ack one cycle after strobe; check S_CYC while waiting.
  task automatic test_read_slave2();
    logic [3:0] cyc_seen;
    int         waitn;
    rd_data[2] = 32'hDEAD_BEEF;
    lat[2]     = 1;
    m_addr  = 32'h2000_0010;
    m_we    = 1'b0;
    m_sel   = 4'hF;
    m_dat_w = '0;
    m_cyc   = 1'b1;
    m_stb   = 1'b1;
    tick();
    cyc_seen = s_cyc;
    n_tests++;
    if (cyc_seen !== 4'b0100) begin
      n_fail++;
      $display("FAIL read2_cyc: got %b, need 0100", cyc_seen);
    end
    waitn = 1;
    while (!m_ack && !m_err && waitn < 40) begin
      tick();
      waitn++;
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
    exp_mdat = 32'hDEAD_BEEF;
    n_tests++;
    if (!(m_ack === 1'b1 && m_err === 1'b0 && m_dat_r === 32'hDEAD_BEEF && waitn == 4)) begin
      n_fail++;
      $display("FAIL read2_resp: got ack=%b err=%b dat=%h edges=%0d, need 1 0 deadbeef 4",
               m_ack, m_err, m_dat_r, waitn);
    end
    tick();
    n_tests++;
    if (m_ack !== 1'b0 || m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL read2_pulse: got ack=%b err=%b after one cycle, need 0 0", m_ack, m_err);
    end
  endtask

  task automatic test_write_slave0();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    lat[0] = 0;
    do_access(32'h0000_0024, 1'b1, 32'h1234_5678, 4'b0011, e, a, er, rd, cb, sc);
    n_tests++;
    if (!(a === 1'b1 && er === 1'b0 && e == 3 && rd === exp_mdat && !cb)) begin
      n_fail++;
      $display("FAIL write0_resp: got ack=%b err=%b edges=%0d dat=%h cyc_bad=%b, need 1 0 3 %h 0",
               a, er, e, rd, cb, exp_mdat);
    end
    n_tests++;
    if (!(cap_dat === 32'h1234_5678 && cap_sel === 4'b0011 && cap_we === 1'b1
          && cap_addr === 32'h0000_0024)) begin
      n_fail++;
      $display("FAIL write0_slave: got addr=%h dat=%h sel=%b we=%b, need 00000024 12345678 0011 1",
               cap_addr, cap_dat, cap_sel, cap_we);
    end
    tick();
  endtask

  task automatic test_unmapped();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    do_access(32'hF000_0000, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    n_tests++;
    if (!(a === 1'b0 && er === 1'b1 && e == 2 && sc == 0 && !cb && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL unmapped: got ack=%b err=%b edges=%0d stb=%0d cyc_bad=%b dat=%h, need 0 1 2 0 0 %h",
               a, er, e, sc, cb, rd, exp_mdat);
    end
    tick();
  endtask

  task automatic test_timeout();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    lat[2] = NEVER;
    do_access(32'h2000_0100, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    n_tests++;
    if (!(a === 1'b0 && er === 1'b1 && sc == TIMEOUT && e == TIMEOUT + 2 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL timeout: got ack=%b err=%b stb_cycles=%0d edges=%0d dat=%h, need 0 1 %0d %0d %h",
               a, er, sc, e, rd, TIMEOUT, TIMEOUT + 2, exp_mdat);
    end
    tick();
    lat[2]     = 0;
    rd_data[2] = 32'hA5A5_0F0F;
    do_access(32'h2000_0104, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    exp_mdat = 32'hA5A5_0F0F;
    n_tests++;
    if (!(a === 1'b1 && er === 1'b0 && e == 3 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL timeout_recover: got ack=%b err=%b edges=%0d dat=%h, need 1 0 3 %h",
               a, er, e, rd, exp_mdat);
    end
    tick();
  endtask

  // Slave ack in the last allowed wait cycle beats the watchdog; one later loses.
  task automatic test_ack_timeout_tie();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    lat[0]     = TIMEOUT - 1;
    rd_data[0] = 32'h0BAD_F00D;
    do_access(32'h0000_0000, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    exp_mdat = 32'h0BAD_F00D;
    n_tests++;
    if (!(a === 1'b1 && er === 1'b0 && e == TIMEOUT + 2 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL tie_ack_wins: got ack=%b err=%b edges=%0d dat=%h, need 1 0 %0d %h",
               a, er, e, rd, TIMEOUT + 2, exp_mdat);
    end
    tick();
    lat[0] = TIMEOUT;
    do_access(32'h0000_0000, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    n_tests++;
    if (!(a === 1'b0 && er === 1'b1 && e == TIMEOUT + 2 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL tie_late_ack: got ack=%b err=%b edges=%0d dat=%h, need 0 1 %0d %h",
               a, er, e, rd, TIMEOUT + 2, exp_mdat);
    end
    tick();
  endtask

  task automatic test_abort();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    logic bad;
    lat[1]  = NEVER;
    m_addr  = 32'h1000_0040;
    m_we    = 1'b0;
    m_sel   = 4'hF;
    m_cyc   = 1'b1;
    m_stb   = 1'b1;
    tick();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
    n_tests++;
    if (s_cyc !== 4'b0000 || s_stb !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_drop: got cyc=%b stb=%b, need 0000 0000", s_cyc, s_stb);
    end
    force_ack[1] = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      force_ack = '0;
      if (m_ack || m_err || s_cyc != 4'b0000) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got spurious ack/err/cyc=%b, need 0", bad);
    end
    lat[1]     = 0;
    rd_data[1] = 32'hC0DE_1111;
    do_access(32'h1000_0044, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    exp_mdat = 32'hC0DE_1111;
    n_tests++;
    if (!(a === 1'b1 && er === 1'b0 && e == 3 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL abort_recover: got ack=%b err=%b edges=%0d dat=%h, need 1 0 3 %h",
               a, er, e, rd, exp_mdat);
    end
    tick();
  endtask

  task automatic test_reset_midwait();
    int e, sc;
    logic a, er, cb;
    logic [31:0] rd;
    lat[3] = NEVER;
    m_addr = 32'h3000_0008;
    m_we   = 1'b0;
    m_sel  = 4'hF;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    tick();
    tick();
    n_tests++;
    if (s_stb !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstwait_pre: got stb=%b, need 1000", s_stb);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (s_cyc !== 4'b0000 || s_stb !== 4'b0000 || m_ack !== 1'b0 || m_dat_r !== 32'h0) begin
      n_fail++;
      $display("FAIL rstwait_async: got cyc=%b stb=%b ack=%b dat=%h, need 0000 0000 0 0",
               s_cyc, s_stb, m_ack, m_dat_r);
    end
    exp_mdat = '0;
    m_cyc = 1'b0;
    m_stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    lat[3]     = 2;
    rd_data[3] = 32'h7777_ABCD;
    do_access(32'h3000_000C, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    exp_mdat = 32'h7777_ABCD;
    n_tests++;
    if (!(a === 1'b1 && er === 1'b0 && e == 5 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL rstwait_recover: got ack=%b err=%b edges=%0d dat=%h, need 1 0 5 %h",
               a, er, e, rd, exp_mdat);
    end
    tick();
  endtask

  // Master holds the request through the ack cycle (classic handshake) and
  // then issues the next access at once: exactly one slave access per request.
  task automatic test_back_to_back();
    int e, sc, acks0, waitn;
    logic a, er, cb;
    logic [31:0] rd;
    lat[0]     = 0;
    rd_data[0] = 32'h1357_9BDF;
    acks0      = n_acks;
    m_addr = 32'h0000_0080;
    m_we   = 1'b0;
    m_sel  = 4'hF;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    waitn  = 0;
    while (!m_ack && waitn < 40) begin
      tick();
      waitn++;
    end
    tick();  // master samples ACK on this edge with the request still up
    m_cyc = 1'b0;
    m_stb = 1'b0;
    exp_mdat = 32'h1357_9BDF;
    lat[1]     = 1;
    rd_data[1] = 32'h2468_ACE0;
    do_access(32'h1000_0000, 1'b0, 32'h0, 4'hF, e, a, er, rd, cb, sc);
    exp_mdat = 32'h2468_ACE0;
    n_tests++;
    if (!(a === 1'b1 && e == 4 && rd === exp_mdat)) begin
      n_fail++;
      $display("FAIL b2b_second: got ack=%b edges=%0d dat=%h, need 1 4 %h", a, e, rd, exp_mdat);
    end
    n_tests++;
    if (n_acks - acks0 != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d slave accesses, need 2", n_acks - acks0);
    end
    tick();
  endtask

  task automatic test_random();
    int e, sc, slv, l, exp_e;
    logic a, er, cb, we, exp_a;
    logic [31:0] addr, wd, rd;
    logic [3:0] sel, nib;
    for (int it = 0; it < 40; it++) begin
      slv = int'($urandom_range(0, 4));
      if (slv == 4) begin
        nib = 4'($urandom_range(4, 15));
        slv = -1;
      end else begin
        nib = 4'(slv);
      end
      addr = {nib, 28'($urandom)};
      we   = 1'($urandom);
      wd   = $urandom;
      sel  = 4'($urandom_range(1, 15));
      l    = int'($urandom_range(0, 4));
      if (l == 4) l = 12;
      if (slv >= 0) begin
        lat[slv]     = l;
        rd_data[slv] = $urandom;
      end
      // reference outcome
      if (slv < 0) begin
        exp_a = 1'b0;
        exp_e = 2;
      end else if (l < TIMEOUT) begin
        exp_a = 1'b1;
        exp_e = l + 3;
        if (!we) exp_mdat = rd_data[slv];
      end else begin
        exp_a = 1'b0;
        exp_e = TIMEOUT + 2;
      end
      do_access(addr, we, wd, sel, e, a, er, rd, cb, sc);
      n_tests++;
      if (!(a === exp_a && er === !exp_a && e == exp_e && rd === exp_mdat && !cb)) begin
        n_fail++;
        $display("FAIL rand_%0d: addr=%h we=%b lat=%0d got ack=%b err=%b edges=%0d dat=%h cyc_bad=%b, need %b %b %0d %h 0",
                 it, addr, we, l, a, er, e, rd, cb, exp_a, !exp_a, exp_e, exp_mdat);
      end
      if (exp_a) begin
        n_tests++;
        if (!(cap_addr === addr && cap_we === we && cap_sel === sel && cap_dat === wd)) begin
          n_fail++;
          $display("FAIL rand_slave_%0d: got addr=%h we=%b sel=%b dat=%h, need %h %b %b %h",
                   it, cap_addr, cap_we, cap_sel, cap_dat, addr, we, sel, wd);
        end
      end
      tick();
      n_tests++;
      if (m_ack !== 1'b0 || m_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_pulse_%0d: got ack=%b err=%b, need 0 0", it, m_ack, m_err);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_read_slave2();
    test_write_slave0();
    test_unmapped();
    test_timeout();
    test_ack_timeout_tie();
    test_abort();
    test_reset_midwait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
